// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions used by the move controller, position decoder and win checker.
package ttt_pkg;

  localparam int CELLS = 9;
  localparam int POS_W = 4;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    DONE
  } move_state_t;

  // Out-of-range indices report "not free" without ever indexing past the map.
  function automatic logic cell_free(input logic [POS_W-1:0] sel,
                                     input logic [CELLS-1:0] occ);
    logic free;
    free = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (int'(sel) == i) free = !occ[i];
    end
    return free;
  endfunction

endpackage

// File: rtl/move_ctrl_if.sv
// Player-side and decoder-side signals of the move controller, bundled as one interface.
interface move_ctrl_if;
  import ttt_pkg::*;

  logic [POS_W-1:0] sel;
  logic             place;
  logic             new_game;
  logic             win_in;
  logic [POS_W-1:0] pos;
  logic             pos_en;
  logic             player;
  logic             illegal;
  logic [3:0]       turn_cnt;
  logic             game_over;
  logic             draw;
  logic             timeout;

  modport master (
    output sel, place, new_game, win_in,
    input  pos, pos_en, player, illegal, turn_cnt, game_over, draw, timeout
  );

  modport slave (
    input  sel, place, new_game, win_in,
    output pos, pos_en, player, illegal, turn_cnt, game_over, draw, timeout
  );

endinterface

// File: rtl/move_timer.sv
// Per-turn idle timer: counts while enabled and pulses expire on its final count.
module move_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

  // Expiry restarts the count so a still-idle player gets a fresh window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/move_ctrl.sv
// Turn sequencer: validates moves, strobes the position decoder and tracks win/draw.
// Optional turn timeout enabled by defining MOVE_TIMEOUT_EN.
module move_ctrl
  import ttt_pkg::*;
#(
  parameter int WIN_LAT     = 1,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic        clk,
  input logic        rst_n,
  move_ctrl_if.slave bus
);

  localparam int WAIT_W = (WIN_LAT > 1) ? $clog2(WIN_LAT) : 1;

  if (WIN_LAT < 1) begin : g_bad_win_lat
    $error("move_ctrl: WIN_LAT must be at least 1");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("move_ctrl: TIMEOUT_CYC must be at least 2");
  end

  move_state_t      state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [POS_W-1:0] pos_q;
  logic [CELLS-1:0] occ;
  logic [3:0]       turn_cnt_q;
  logic             player_q;
  logic             illegal_q;
  logic             game_over_q;
  logic             draw_q;
  logic             timeout_q;
  logic             timeout_fire;
  logic             sel_free;
  logic             legal_place;
  logic             rejected_place;
  logic             wait_done;
  logic             board_full;

  assign sel_free       = cell_free(bus.sel, occ);
  assign legal_place    = (state == IDLE) && bus.place && sel_free;
  assign rejected_place = (state == IDLE) && bus.place && !sel_free;
  assign wait_done      = (state == WAIT_RES) && (wait_cnt == '0);
  assign board_full     = (turn_cnt_q == 4'(CELLS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.new_game) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:     if (legal_place) next_state = ISSUE;
        ISSUE:    next_state = WAIT_RES;
        WAIT_RES: if (wait_done) next_state = (bus.win_in || board_full) ? DONE : IDLE;
        DONE:     next_state = DONE;
        default:  next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.pos       = pos_q;
    bus.pos_en    = (state == ISSUE);
    bus.player    = player_q;
    bus.illegal   = illegal_q;
    bus.turn_cnt  = turn_cnt_q;
    bus.game_over = game_over_q;
    bus.draw      = draw_q;
    bus.timeout   = timeout_q;
  end

  // new_game clears everything but pos; a verdict of win outranks a full board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= '0;
      occ         <= '0;
      turn_cnt_q  <= '0;
      player_q    <= PLAYER_X;
      illegal_q   <= 1'b0;
      game_over_q <= 1'b0;
      draw_q      <= 1'b0;
      wait_cnt    <= '0;
    end else if (bus.new_game) begin
      occ         <= '0;
      turn_cnt_q  <= '0;
      player_q    <= PLAYER_X;
      illegal_q   <= 1'b0;
      game_over_q <= 1'b0;
      draw_q      <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      illegal_q <= rejected_place;
      if (legal_place) pos_q <= bus.sel;
      if (state == ISSUE) begin
        for (int i = 0; i < CELLS; i++) begin
          if (int'(pos_q) == i) occ[i] <= 1'b1;
        end
        turn_cnt_q <= turn_cnt_q + 4'd1;
        wait_cnt   <= WAIT_W'(WIN_LAT - 1);
      end
      if ((state == WAIT_RES) && !wait_done) wait_cnt <= wait_cnt - WAIT_W'(1);
      if (wait_done) begin
        if (bus.win_in)     game_over_q <= 1'b1;
        else if (board_full) draw_q     <= 1'b1;
        else                player_q    <= ~player_q;
      end else if (timeout_fire) begin
        player_q <= ~player_q;
      end
    end
  end

`ifdef MOVE_TIMEOUT_EN
  logic timer_load;
  logic timer_expire;

  // Restart the window on every fresh turn; rejected attempts keep it running.
  assign timer_load   = bus.new_game || ((state != IDLE) && (next_state == IDLE));
  assign timeout_fire = timer_expire && !legal_place && !bus.new_game;

  move_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .enable (state == IDLE),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            timeout_q <= 1'b0;
    else if (bus.new_game) timeout_q <= 1'b0;
    else                   timeout_q <= timeout_fire;
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_q    = 1'b0;
`endif

endmodule

// File: tb/tb_move_ctrl.sv
// Self-checking bench for move_ctrl; decoder pulses are checked against a queue of expected events.
module tb_move_ctrl;
  import ttt_pkg::*;

  localparam int WIN_LAT     = 1;
  localparam int TIMEOUT_CYC = 8;

  typedef struct {
    logic             is_pos;
    logic [POS_W-1:0] pos;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [15:0] m_occ;
  int          m_turn;
  logic        m_player, m_over, m_draw;

  move_ctrl_if bus ();

  move_ctrl #(
    .WIN_LAT     (WIN_LAT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pos_en/illegal pulse must match the oldest expected event, in the expected cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pos_en && bus.illegal) begin
        total++; bad++;
        $display("[TB] FAIL pulse_overlap cyc=%0d pos_en=1 illegal=1 required never both", cyc);
      end
      if (bus.pos_en || bus.illegal) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_pulse cyc=%0d pos_en=%b illegal=%b pos=%0d required no pulse",
                   cyc, bus.pos_en, bus.illegal, bus.pos);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.is_pos !== bus.pos_en || mon_e.cyc != cyc || (mon_e.is_pos && bus.pos !== mon_e.pos)) begin
            bad++;
            $display("[TB] FAIL pulse cyc=%0d pos_en=%b pos=%0d required cyc=%0d pos_en=%b pos=%0d",
                     cyc, bus.pos_en, bus.pos, mon_e.cyc, mon_e.is_pos, mon_e.pos);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        total++; bad++;
        mon_e = sb.pop_front();
        $display("[TB] FAIL missing_pulse cyc=%0d got none required pos_en=%b pos=%0d",
                 cyc, mon_e.is_pos, mon_e.pos);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_occ = '0; m_turn = 0; m_player = PLAYER_X; m_over = 1'b0; m_draw = 1'b0;
  endtask

  task automatic do_new_game;
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    model_reset();
  endtask

  task automatic drive_place(input logic [POS_W-1:0] s, output logic legal);
    exp_t e;
    legal = 1'b0;
    if (!m_over && !m_draw) begin
      legal = (int'(s) < CELLS) && !m_occ[s];
      e = '{legal, s, cyc + 1};
      sb.push_back(e);
    end
    bus.sel   = s;
    bus.place = 1'b1;
    tick();
    bus.place = 1'b0;
  endtask

  task automatic commit_move(input logic [POS_W-1:0] s, input logic w);
    m_occ[s] = 1'b1;
    m_turn++;
    if (w)                   m_over = 1'b1;
    else if (m_turn == CELLS) m_draw = 1'b1;
    else                     m_player = ~m_player;
  endtask

  task automatic move(input logic [POS_W-1:0] s, input logic w);
    logic legal;
    drive_place(s, legal);
    if (legal) begin
      repeat (WIN_LAT) tick();
      bus.win_in = w;
      tick();
      bus.win_in = 1'b0;
      commit_move(s, w);
    end else begin
      tick();
    end
  endtask

  task automatic test_reset;
    bus.sel = '0; bus.place = 1'b0; bus.new_game = 1'b0; bus.win_in = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    total++;
    if (bus.pos !== 4'd0 || bus.pos_en !== 1'b0 || bus.illegal !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_pulses got pos=%0d pos_en=%b illegal=%b required 0/0/0", bus.pos, bus.pos_en, bus.illegal);
    end
    total++;
    if (bus.player !== 1'b0 || bus.turn_cnt !== 4'd0) begin
      bad++; $display("[TB] FAIL reset_turn got player=%b turn_cnt=%0d required 0/0", bus.player, bus.turn_cnt);
    end
    total++;
    if (bus.game_over !== 1'b0 || bus.draw !== 1'b0 || bus.timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_status got over=%b draw=%b timeout=%b required 0/0/0", bus.game_over, bus.draw, bus.timeout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_legal_move;
    logic legal;
    do_new_game();
    drive_place(4'd4, legal);
    total++;
    if (bus.pos_en !== 1'b1 || bus.pos !== 4'd4 || bus.turn_cnt !== 4'd0) begin
      bad++; $display("[TB] FAIL first_issue got pos_en=%b pos=%0d turn_cnt=%0d required 1/4/0", bus.pos_en, bus.pos, bus.turn_cnt);
    end
    repeat (WIN_LAT) tick();
    bus.win_in = 1'b0;
    total++;
    if (bus.pos_en !== 1'b0 || bus.player !== 1'b0 || bus.turn_cnt !== 4'd1) begin
      bad++; $display("[TB] FAIL wait_res got pos_en=%b player=%b turn_cnt=%0d required 0/0/1", bus.pos_en, bus.player, bus.turn_cnt);
    end
    tick();
    commit_move(4'd4, 1'b0);
    total++;
    if (bus.player !== 1'b1 || bus.turn_cnt !== 4'd1) begin
      bad++; $display("[TB] FAIL player_toggle got player=%b turn_cnt=%0d required 1/1", bus.player, bus.turn_cnt);
    end
  endtask

  task automatic test_illegal;
    logic [POS_W-1:0] bad_sel [3];
    bad_sel = '{4'd4, 4'd9, 4'd15};
    foreach (bad_sel[i]) begin
      move(bad_sel[i], 1'b0);
      total++;
      if (bus.player !== m_player || bus.turn_cnt !== 4'(m_turn) || bus.pos !== 4'd4) begin
        bad++; $display("[TB] FAIL illegal_sel%0d got player=%b turn_cnt=%0d pos=%0d required %b/%0d/4",
                        bad_sel[i], bus.player, bus.turn_cnt, bus.pos, m_player, m_turn);
      end
    end
  endtask

  task automatic test_win;
    logic [POS_W-1:0] seq [4];
    seq = '{4'd0, 4'd3, 4'd1, 4'd4};
    do_new_game();
    foreach (seq[i]) move(seq[i], 1'b0);
    move(4'd2, 1'b1);
    total++;
    if (bus.game_over !== 1'b1 || bus.player !== PLAYER_X || bus.draw !== 1'b0 || bus.turn_cnt !== 4'd5) begin
      bad++; $display("[TB] FAIL win got over=%b player=%b draw=%b turn_cnt=%0d required 1/0/0/5",
                      bus.game_over, bus.player, bus.draw, bus.turn_cnt);
    end
    move(4'd5, 1'b0);
    tick();
    total++;
    if (bus.game_over !== 1'b1 || bus.turn_cnt !== 4'd5 || bus.pos !== 4'd2) begin
      bad++; $display("[TB] FAIL done_hold got over=%b turn_cnt=%0d pos=%0d required 1/5/2", bus.game_over, bus.turn_cnt, bus.pos);
    end
  endtask

  task automatic test_draw;
    do_new_game();
    for (int i = 0; i < CELLS; i++) move(4'(i), 1'b0);
    total++;
    if (bus.draw !== 1'b1 || bus.game_over !== 1'b0 || bus.turn_cnt !== 4'd9) begin
      bad++; $display("[TB] FAIL draw got draw=%b over=%b turn_cnt=%0d required 1/0/9", bus.draw, bus.game_over, bus.turn_cnt);
    end
    do_new_game();
    for (int i = 0; i < CELLS; i++) move(4'(i), i == CELLS - 1);
    total++;
    if (bus.game_over !== 1'b1 || bus.draw !== 1'b0 || bus.turn_cnt !== 4'd9 || bus.player !== m_player) begin
      bad++; $display("[TB] FAIL ninth_win got over=%b draw=%b turn_cnt=%0d player=%b required 1/0/9/%b",
                      bus.game_over, bus.draw, bus.turn_cnt, bus.player, m_player);
    end
  endtask

  task automatic test_new_game;
    logic legal;
    do_new_game();
    move(4'd0, 1'b0);
    drive_place(4'd2, legal);
    tick();
    bus.new_game = 1'b1;
    bus.win_in   = 1'b1;
    tick();
    bus.new_game = 1'b0;
    bus.win_in   = 1'b0;
    model_reset();
    total++;
    if (bus.turn_cnt !== 4'd0 || bus.player !== 1'b0 || bus.game_over !== 1'b0) begin
      bad++; $display("[TB] FAIL ng_wait_res got turn_cnt=%0d player=%b over=%b required 0/0/0", bus.turn_cnt, bus.player, bus.game_over);
    end
    move(4'd4, 1'b0);
    move(4'd0, 1'b0);
    total++;
    if (bus.turn_cnt !== 4'd2 || bus.player !== 1'b0) begin
      bad++; $display("[TB] FAIL ng_reaccept got turn_cnt=%0d player=%b required 2/0", bus.turn_cnt, bus.player);
    end
    move(4'd5, 1'b1);
    do_new_game();
    total++;
    if (bus.game_over !== 1'b0 || bus.turn_cnt !== 4'd0 || bus.player !== 1'b0 || bus.pos !== 4'd5) begin
      bad++; $display("[TB] FAIL ng_done got over=%b turn_cnt=%0d player=%b pos=%0d required 0/0/0/5",
                      bus.game_over, bus.turn_cnt, bus.player, bus.pos);
    end
    move(4'd5, 1'b0);
    drive_place(4'd7, legal);
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    model_reset();
    total++;
    if (bus.turn_cnt !== 4'd0 || bus.pos_en !== 1'b0) begin
      bad++; $display("[TB] FAIL ng_issue got turn_cnt=%0d pos_en=%b required 0/0", bus.turn_cnt, bus.pos_en);
    end
    bus.new_game = 1'b1;
    bus.sel      = 4'd3;
    bus.place    = 1'b1;
    tick();
    bus.new_game = 1'b0;
    bus.place    = 1'b0;
    tick();
    move(4'd7, 1'b0);
    total++;
    if (bus.turn_cnt !== 4'd1 || bus.player !== 1'b1) begin
      bad++; $display("[TB] FAIL ng_priority got turn_cnt=%0d player=%b required 1/1", bus.turn_cnt, bus.player);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    do_new_game();
    e = '{1'b1, 4'd6, cyc + 1};
    sb.push_back(e);
    bus.sel   = 4'd6;
    bus.place = 1'b1;
    tick();
    bus.sel   = 4'd2;
    tick();
    bus.place = 1'b0;
    repeat (WIN_LAT - 1) tick();
    bus.win_in = 1'b0;
    tick();
    commit_move(4'd6, 1'b0);
    total++;
    if (bus.turn_cnt !== 4'd1 || bus.player !== 1'b1) begin
      bad++; $display("[TB] FAIL held_place got turn_cnt=%0d player=%b required 1/1", bus.turn_cnt, bus.player);
    end
    move(4'd2, 1'b0);
    total++;
    if (bus.turn_cnt !== 4'd2 || bus.player !== 1'b0) begin
      bad++; $display("[TB] FAIL back_to_back got turn_cnt=%0d player=%b required 2/0", bus.turn_cnt, bus.player);
    end
  endtask

  task automatic test_reset_mid_issue;
    do_new_game();
    bus.sel   = 4'd8;
    bus.place = 1'b1;
    tick();
    bus.place = 1'b0;
    total++;
    if (bus.pos_en !== 1'b1) begin
      bad++; $display("[TB] FAIL issue_before_reset got pos_en=%b required 1", bus.pos_en);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.pos_en !== 1'b0 || bus.pos !== 4'd0) begin
      bad++; $display("[TB] FAIL async_reset got pos_en=%b pos=%0d required 0/0", bus.pos_en, bus.pos);
    end
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_timeout;
    logic legal;
    do_new_game();
`ifdef MOVE_TIMEOUT_EN
    repeat (TIMEOUT_CYC - 1) tick();
    total++;
    if (bus.timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_early got timeout=%b required 0", bus.timeout);
    end
    tick();
    m_player = ~m_player;
    total++;
    if (bus.timeout !== 1'b1 || bus.player !== 1'b1 || bus.turn_cnt !== 4'd0) begin
      bad++; $display("[TB] FAIL timeout_pulse got timeout=%b player=%b turn_cnt=%0d required 1/1/0", bus.timeout, bus.player, bus.turn_cnt);
    end
    tick();
    total++;
    if (bus.timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_width got timeout=%b required 0", bus.timeout);
    end
    repeat (TIMEOUT_CYC - 2) tick();
    drive_place(4'd4, legal);
    total++;
    if (bus.timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL place_on_expiry got timeout=%b required 0", bus.timeout);
    end
    repeat (WIN_LAT) tick();
    tick();
    commit_move(4'd4, 1'b0);
    total++;
    if (bus.player !== m_player || bus.turn_cnt !== 4'd1) begin
      bad++; $display("[TB] FAIL after_expiry_move got player=%b turn_cnt=%0d required %b/1", bus.player, bus.turn_cnt, m_player);
    end
`else
    legal = 1'b0;
    repeat (3 * TIMEOUT_CYC) tick();
    total++;
    if (bus.timeout !== 1'b0 || bus.player !== 1'b0 || legal !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_off got timeout=%b player=%b required 0/0", bus.timeout, bus.player);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_legal_move();
    test_illegal();
    test_win();
    test_draw();
    test_new_game();
    test_back_to_back();
    test_reset_mid_issue();
    test_timeout();
    repeat (3) tick();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("[TB] FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
